// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, ALU opcodes,
// datapath select codes and the instruction fields it decodes.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        DCD   = 3'd1,
        EXE   = 3'd2,
        MEM   = 3'd3,
        WB    = 3'd4
    } state_t;

    // ALU operation codes, shared with the datapath ALU
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_SRA = 3'b101;

    localparam logic [1:0] EXT_ZERO  = 2'b00;
    localparam logic [1:0] EXT_SIGN  = 2'b01;
    localparam logic [1:0] EXT_UPPER = 2'b10;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC4 = 2'b10;

    localparam logic [1:0] NPC_PC4 = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J26 = 2'b10;
    localparam logic [1:0] NPC_REG = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_JR   = 6'b001000;

    // One-hot instruction class produced by the decoder
    typedef struct packed {
        logic rtype_alu;
        logic jr;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic undef;
    } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: op/funct to a one-hot class vector plus
// the ALU operation and operand-swap control for that instruction.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output iclass_t    iclass,
    output logic [2:0] aluop,
    output logic       aswap
);

    always_comb begin
        iclass = '0;
        aluop  = ALU_ADD;
        aswap  = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: begin iclass.rtype_alu = 1'b1; aluop = ALU_ADD; end
                    FN_SUBU: begin iclass.rtype_alu = 1'b1; aluop = ALU_SUB; end
                    FN_AND:  begin iclass.rtype_alu = 1'b1; aluop = ALU_AND; end
                    FN_OR:   begin iclass.rtype_alu = 1'b1; aluop = ALU_OR;  end
                    // variable shifts shift rt by rs, so the operands swap
                    FN_SRLV: begin iclass.rtype_alu = 1'b1; aluop = ALU_SRL; aswap = 1'b1; end
                    FN_SRAV: begin iclass.rtype_alu = 1'b1; aluop = ALU_SRA; aswap = 1'b1; end
                    FN_JR:   iclass.jr = 1'b1;
                    default: iclass.undef = 1'b1;
                endcase
            end
            OP_ORI:  begin iclass.ori = 1'b1; aluop = ALU_OR;  end
            OP_LUI:  begin iclass.lui = 1'b1; aluop = ALU_OR;  end
            OP_LW:   begin iclass.lw  = 1'b1; aluop = ALU_ADD; end
            OP_SW:   begin iclass.sw  = 1'b1; aluop = ALU_ADD; end
            OP_BEQ:  begin iclass.beq = 1'b1; aluop = ALU_SUB; end
            OP_J:    iclass.j   = 1'b1;
            OP_JAL:  iclass.jal = 1'b1;
            default: iclass.undef = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: five-state FSM driving datapath enables,
// mux selects and the ALU opcode from the decoded instruction register.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] state,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RegWr,
    output logic       MemWr,
    output logic [2:0] ALUOp,
    output logic       ALUSrc,
    output logic       ASwap,
    output logic [1:0] ExtOp,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic [1:0] NPCOp
);

    state_t     cur_state;
    state_t     nxt_state;
    iclass_t    iclass;
    logic [2:0] dec_aluop;
    logic       dec_aswap;

    mc_decode u_decode (
        .op     (op),
        .funct  (funct),
        .iclass (iclass),
        .aluop  (dec_aluop),
        .aswap  (dec_aswap)
    );

    assign state = cur_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur_state <= FETCH;
        else       cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = cur_state;
        PCWr      = 1'b0;
        IRWr      = 1'b0;
        RegWr     = 1'b0;
        MemWr     = 1'b0;
        ALUOp     = ALU_ADD;
        ALUSrc    = 1'b0;
        ASwap     = 1'b0;
        ExtOp     = EXT_ZERO;
        RegDst    = DST_RT;
        MemtoReg  = WD_ALU;
        NPCOp     = NPC_PC4;

        // ALU controls stay put from EXE to WB so the result is stable at write-back
        if (cur_state == EXE || cur_state == MEM || cur_state == WB) begin
            ALUOp  = dec_aluop;
            ASwap  = dec_aswap;
            ALUSrc = iclass.ori | iclass.lui | iclass.lw | iclass.sw;
            if (iclass.lw || iclass.sw) ExtOp = EXT_SIGN;
            else if (iclass.lui)        ExtOp = EXT_UPPER;
        end

        case (cur_state)
            FETCH: begin
                IRWr      = 1'b1;
                PCWr      = 1'b1;
                nxt_state = DCD;
            end
            DCD: begin
                nxt_state = FETCH;
                if (iclass.j) begin
                    PCWr  = 1'b1;
                    NPCOp = NPC_J26;
                end else if (iclass.jal) begin
                    PCWr     = 1'b1;
                    NPCOp    = NPC_J26;
                    RegWr    = 1'b1;
                    RegDst   = DST_RA;
                    MemtoReg = WD_PC4;
                end else if (iclass.jr) begin
                    PCWr  = 1'b1;
                    NPCOp = NPC_REG;
                end else if (!iclass.undef) begin
                    nxt_state = EXE;
                end
            end
            EXE: begin
                if (iclass.beq) begin
                    NPCOp     = NPC_BR;
                    PCWr      = zero;
                    nxt_state = FETCH;
                end else if (iclass.lw || iclass.sw) begin
                    nxt_state = MEM;
                end else begin
                    nxt_state = WB;
                end
            end
            MEM: begin
                if (iclass.sw) begin
                    MemWr     = 1'b1;
                    nxt_state = FETCH;
                end else begin
                    nxt_state = WB;
                end
            end
            WB: begin
                RegWr     = 1'b1;
                RegDst    = iclass.rtype_alu ? DST_RD : DST_RT;
                MemtoReg  = iclass.lw ? WD_MEM : WD_ALU;
                nxt_state = FETCH;
            end
            default: nxt_state = FETCH;
        endcase

        // no write may escape while reset is held, even though state reads FETCH
        if (reset) begin
            PCWr  = 1'b0;
            IRWr  = 1'b0;
            RegWr = 1'b0;
            MemWr = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized self-checking bench for mc_ctrl against a per-instruction
// cycle-by-cycle behavioural model of the control outputs.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] state;
    logic       PCWr, IRWr, RegWr, MemWr;
    logic [2:0] ALUOp;
    logic       ALUSrc, ASwap;
    logic [1:0] ExtOp, RegDst, MemtoReg, NPCOp;

    int total = 0;
    int bad   = 0;

    localparam int C_ALU = 0, C_JR = 1, C_ORI = 2, C_LUI = 3, C_LW = 4,
                   C_SW = 5, C_BEQ = 6, C_J = 7, C_JAL = 8, C_UND = 9;

    mc_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .funct    (funct),
        .zero     (zero),
        .state    (state),
        .PCWr     (PCWr),
        .IRWr     (IRWr),
        .RegWr    (RegWr),
        .MemWr    (MemWr),
        .ALUOp    (ALUOp),
        .ALUSrc   (ALUSrc),
        .ASwap    (ASwap),
        .ExtOp    (ExtOp),
        .RegDst   (RegDst),
        .MemtoReg (MemtoReg),
        .NPCOp    (NPCOp)
    );

    always #5 clk = ~clk;

    wire [19:0] outv = {state, PCWr, IRWr, RegWr, MemWr, ALUOp, ALUSrc, ASwap,
                        ExtOp, RegDst, MemtoReg, NPCOp};

    task automatic checkOutput(input string tag, input logic [19:0] got, input logic [19:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%05h expected=%05h", tag, got, exp);
        end
    endtask

    // Instruction class and its ALU settings straight from the instruction table
    task automatic classify(input logic [5:0] iop, input logic [5:0] ifn, output int cls,
                            output logic [2:0] aop, output logic asrc, output logic asw,
                            output logic [1:0] ext);
        cls = C_UND; aop = 3'b000; asrc = 1'b0; asw = 1'b0; ext = 2'b00;
        if (iop == 6'b000000) begin
            case (ifn)
                6'b100001: begin cls = C_ALU; aop = 3'b000; end
                6'b100011: begin cls = C_ALU; aop = 3'b001; end
                6'b100100: begin cls = C_ALU; aop = 3'b010; end
                6'b100101: begin cls = C_ALU; aop = 3'b011; end
                6'b000110: begin cls = C_ALU; aop = 3'b100; asw = 1'b1; end
                6'b000111: begin cls = C_ALU; aop = 3'b101; asw = 1'b1; end
                6'b001000: cls = C_JR;
                default:   cls = C_UND;
            endcase
        end else begin
            case (iop)
                6'b001101: begin cls = C_ORI; aop = 3'b011; asrc = 1'b1; ext = 2'b00; end
                6'b001111: begin cls = C_LUI; aop = 3'b011; asrc = 1'b1; ext = 2'b10; end
                6'b100011: begin cls = C_LW;  aop = 3'b000; asrc = 1'b1; ext = 2'b01; end
                6'b101011: begin cls = C_SW;  aop = 3'b000; asrc = 1'b1; ext = 2'b01; end
                6'b000100: begin cls = C_BEQ; aop = 3'b001; end
                6'b000010: cls = C_J;
                6'b000011: cls = C_JAL;
                default:   cls = C_UND;
            endcase
        end
    endtask

    function automatic int cyclesOf(input int cls);
        case (cls)
            C_J, C_JAL, C_JR, C_UND: return 2;
            C_BEQ:                   return 3;
            C_LW:                    return 5;
            default:                 return 4;
        endcase
    endfunction

    // Expected outputs for cycle k (0 = FETCH) of an instruction of class cls
    function automatic logic [19:0] model(input int cls, input int k, input logic z,
                                          input logic [2:0] aop, input logic asrc,
                                          input logic asw, input logic [1:0] ext);
        logic [2:0] st = 3'd0, ea = 3'd0;
        logic pw = 0, iw = 0, rw = 0, mw = 0, es = 0, ew = 0;
        logic [1:0] ee = 0, rd = 0, m2r = 0, npc = 0;
        if (k >= 2) begin ea = aop; es = asrc; ew = asw; ee = ext; end
        case (k)
            0: begin st = 3'd0; pw = 1; iw = 1; end
            1: begin
                st = 3'd1;
                if (cls == C_J)   begin pw = 1; npc = 2'b10; end
                if (cls == C_JAL) begin pw = 1; npc = 2'b10; rw = 1; rd = 2'b10; m2r = 2'b10; end
                if (cls == C_JR)  begin pw = 1; npc = 2'b11; end
            end
            2: begin
                st = 3'd2;
                if (cls == C_BEQ) begin npc = 2'b01; pw = z; end
            end
            3: begin
                if (cls == C_LW || cls == C_SW) begin
                    st = 3'd3;
                    mw = (cls == C_SW);
                end else begin
                    st = 3'd4; rw = 1; rd = (cls == C_ALU) ? 2'b01 : 2'b00;
                end
            end
            default: begin st = 3'd4; rw = 1; m2r = 2'b01; end
        endcase
        return {st, pw, iw, rw, mw, ea, es, ew, ee, rd, m2r, npc};
    endfunction

    // Run one instruction; zmode 0/1 forces zero, 2 randomizes it; abort_at injects reset
    task automatic applyStimulus(input logic [5:0] iop, input logic [5:0] ifn, input int zmode,
                                 input int abort_at, input string name);
        int cls;
        logic [2:0] aop;
        logic asrc, asw;
        logic [1:0] ext;
        classify(iop, ifn, cls, aop, asrc, asw, ext);
        for (int k = 0; k < cyclesOf(cls); k++) begin
            @(negedge clk);
            op    = (k == 0) ? 6'($urandom) : iop;
            funct = (k == 0) ? 6'($urandom) : ifn;
            zero  = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
            if (k == abort_at) begin
                reset = 1'b1;
                #1 checkOutput({name, "_rst_now"}, outv, 20'h0);
                @(posedge clk);
                #1 checkOutput({name, "_rst_hold"}, outv, 20'h0);
                #1 reset = 1'b0;
                return;
            end
            #1 checkOutput($sformatf("%s_c%0d", name, k), outv,
                           model(cls, k, zero, aop, asrc, asw, ext));
        end
    endtask

    logic [5:0] rops [17];
    logic [5:0] rfns [17];

    initial begin
        reset = 1'b1; op = '0; funct = '0; zero = 1'b0;
        rops = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'b001101, 6'b001111,
                 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b000011, 6'h00, 6'b111111, 6'h00};
        rfns = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b000110, 6'b000111, 6'b001000,
                 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'b101010};

        @(negedge clk); #1 checkOutput("reset_a", outv, 20'h0);
        @(negedge clk); #1 checkOutput("reset_b", outv, 20'h0);
        @(posedge clk); #2 reset = 1'b0;

        applyStimulus(6'b000000, 6'b100001, 2, -1, "addu");
        applyStimulus(6'b100011, 6'b010101, 2, -1, "lw");
        applyStimulus(6'b101011, 6'b000000, 2, -1, "sw");
        applyStimulus(6'b000100, 6'b000000, 1, -1, "beq_taken");
        applyStimulus(6'b000100, 6'b000000, 0, -1, "beq_not");
        applyStimulus(6'b000011, 6'b000000, 2, -1, "jal");
        applyStimulus(6'b000000, 6'b000111, 2, -1, "srav");
        applyStimulus(6'b111111, 6'b000000, 2, -1, "undef");
        applyStimulus(6'b101011, 6'b000000, 2, 3,  "sw_abort");
        applyStimulus(6'b000000, 6'b000000, 2, -1, "sll");

        for (int n = 0; n < 300; n++) begin
            int idx;
            logic [5:0] rf;
            idx = $urandom_range(0, 16);
            rf  = (rops[idx] == 6'h00) ? rfns[idx] : 6'($urandom);
            applyStimulus(rops[idx], rf, 2, ($urandom_range(0, 19) == 0) ? 2 : -1,
                          $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
